// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the EX-stage arithmetic units and the hazard unit.
//   Contents:
//     div_state_e    - sequential divider FSM states (2-bit encoding)
//     DIV_WIDTH      - default operand/result width of the divider
//     HILO_WSEL_*    - HI/LO write-select codes the hazard unit uses to track
//                      which of the HI/LO registers a pending op will write
package cpu_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_FIX  = 2'b10
    } div_state_e;

    localparam logic [1:0] HILO_WSEL_NONE = 2'b00;
    localparam logic [1:0] HILO_WSEL_LO   = 2'b01;
    localparam logic [1:0] HILO_WSEL_HI   = 2'b10;
    localparam logic [1:0] HILO_WSEL_BOTH = 2'b11;

endpackage

// File: rtl/twos_negate.sv
// twos_negate
//   Combinational two's complement negation (~x + 1). The divider uses it to
//   take operand magnitudes and to re-apply signs to the results.
//   Ports:
//     value_i  in   WIDTH  value to negate
//     neg_o    out  WIDTH  two's complement negation of value_i
module twos_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [WIDTH-1:0] neg_o
);

    assign neg_o = ~value_i + WIDTH'(1);

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Multi-cycle radix-2 restoring divider serving MIPS DIV/DIVU. Quotient is
//   the LO result and remainder the HI result. Latency is fixed (WIDTH+1
//   cycles from acceptance to done) for every operand value so the hazard
//   logic can count cycles instead of watching busy.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      asynchronous active-low reset
//     start      in   1      request, sampled only while idle
//     signed_op  in   1      1 = DIV (two's complement), 0 = DIVU
//     dividend   in   WIDTH  rs operand, captured on acceptance
//     divisor    in   WIDTH  rt operand, captured on acceptance
//     busy       out  1      high from the cycle after acceptance until done
//     done       out  1      one-cycle pulse, results valid from this cycle
//     quotient   out  WIDTH  LO result, held until the next completion
//     remainder  out  WIDTH  HI result, held until the next completion
//     div_zero   out  1      divisor was zero for the completed op
module seq_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] dvnd_q;
    logic             dvnd_neg_q;
    logic             dvsr_neg_q;
    logic             zero_q;

    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_zero_q;
    logic             done_q;

    logic             accept;
    logic             dvnd_neg;
    logic             dvsr_neg;
    logic [WIDTH-1:0] dvnd_negated;
    logic [WIDTH-1:0] dvsr_negated;
    logic [WIDTH-1:0] dvnd_mag;
    logic [WIDTH-1:0] dvsr_mag;
    logic [WIDTH-1:0] quo_negated;
    logic [WIDTH-1:0] rem_negated;

    logic [WIDTH:0]   shifted;
    logic             trial_ok;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quotient_fix;
    logic [WIDTH-1:0] remainder_fix;

    assign accept = (state_q == DIV_IDLE) && start;

    // Operand signs only matter for DIV; DIVU treats the MSB as magnitude.
    assign dvnd_neg = signed_op && dividend[WIDTH-1];
    assign dvsr_neg = signed_op && divisor[WIDTH-1];

    twos_negate #(.WIDTH(WIDTH)) u_neg_dvnd (.value_i(dividend), .neg_o(dvnd_negated));
    twos_negate #(.WIDTH(WIDTH)) u_neg_dvsr (.value_i(divisor),  .neg_o(dvsr_negated));
    twos_negate #(.WIDTH(WIDTH)) u_neg_quo  (.value_i(quo_q),    .neg_o(quo_negated));
    twos_negate #(.WIDTH(WIDTH)) u_neg_rem  (.value_i(rem_q),    .neg_o(rem_negated));

    assign dvnd_mag = dvnd_neg ? dvnd_negated : dividend;
    assign dvsr_mag = dvsr_neg ? dvsr_negated : divisor;

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value fits WIDTH+1 bits and, whichever branch is taken,
    // the new remainder fits back into WIDTH bits. The subtraction can be
    // done modulo 2**WIDTH because it is only kept when it cannot underflow.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial_ok = (shifted >= {1'b0, dvsr_q});
    assign trial    = shifted[WIDTH-1:0] - dvsr_q;
    assign rem_next = trial_ok ? trial : shifted[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], trial_ok};

    // Sign fix-up. Divide-by-zero overrides the iterated result: quotient is
    // all ones and remainder is the untouched original dividend. The signed
    // most-negative / -1 case needs no special handling: its magnitude
    // quotient negates back onto itself.
    always_comb begin
        quotient_fix  = (dvnd_neg_q ^ dvsr_neg_q) ? quo_negated : quo_q;
        remainder_fix = dvnd_neg_q ? rem_negated : rem_q;
        if (zero_q) begin
            quotient_fix  = '1;
            remainder_fix = dvnd_q;
        end
    end

    // Next-state logic: IDLE waits for start, CALC runs exactly WIDTH
    // steps, FIX spends one cycle loading the results.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = DIV_CALC;
                    cnt_d   = '0;
                end
            end
            DIV_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                state_d = DIV_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = DIV_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath: operand capture on acceptance, one shift/subtract per CALC
    // cycle, and result registers that only change on the done edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            dvnd_q      <= '0;
            dvnd_neg_q  <= 1'b0;
            dvsr_neg_q  <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                rem_q      <= '0;
                quo_q      <= dvnd_mag;
                dvsr_q     <= dvsr_mag;
                dvnd_q     <= dividend;
                dvnd_neg_q <= dvnd_neg;
                dvsr_neg_q <= dvsr_neg;
                zero_q     <= (divisor == '0);
            end else if (state_q == DIV_CALC) begin
                rem_q <= rem_next;
                quo_q <= quo_next;
            end else if (state_q == DIV_FIX) begin
                quotient_q  <= quotient_fix;
                remainder_q <= remainder_fix;
                div_zero_q  <= zero_q;
                done_q      <= 1'b1;
            end
        end
    end

    assign busy      = (state_q != DIV_IDLE);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Self-checking bench for seq_divider. Expected results come from a plain
//   arithmetic model of MIPS DIV/DIVU semantics; latency is counted in clock
//   edges from acceptance to the first cycle with done high.
module tb_seq_divider;

    localparam int W       = 32;
    localparam int LATENCY = 33;
    localparam int TIMEOUT = 60;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          signed_op;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_zero;

    int passCount  = 0;
    int checkCount = 0;

    seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: MIPS DIV/DIVU with truncation toward zero.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        int sa, sb;
        sa = a;
        sb = b;
        z  = (b == 0);
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issues one op from a cycle where the DUT is idle (called #1 after a
    // rising edge), scrambles the operand inputs after acceptance, and
    // returns in the done cycle with the number of edges waited.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat);
        start     = 1'b1;
        signed_op = s;
        dividend  = a;
        divisor   = b;
        @(posedge clk); #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        signed_op = 1'($urandom_range(0, 1));
        lat = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        checkCount++;
        if ({busy, done, div_zero} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, div_zero});
        else passCount++;
        checkCount++;
        if (quotient !== '0 || remainder !== '0) $display("[TB] FAIL reset_results: got q=%h r=%h expected 0/0", quotient, remainder);
        else passCount++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_divu_basic();
        int lat;
        logic [W-1:0] hq, hr;
        run_op(32'd100, 32'd7, 1'b0, lat);
        checkCount++;
        if (lat !== LATENCY) $display("[TB] FAIL divu_latency: got %0d expected %0d", lat, LATENCY);
        else passCount++;
        checkCount++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_zero !== 1'b0)
            $display("[TB] FAIL divu_100_7: got q=%h r=%h z=%b expected q=0000000e r=00000002 z=0", quotient, remainder, div_zero);
        else passCount++;
        hq = quotient; hr = remainder;
        @(posedge clk); #1;
        checkCount++;
        if (done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2)
            $display("[TB] FAIL done_pulse_hold: got done=%b q=%h r=%h expected done=0 q=0000000e r=00000002", done, quotient, remainder);
        else passCount++;
    endtask

    task automatic test_signed();
        int lat;
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
        checkCount++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF || lat !== LATENCY)
            $display("[TB] FAIL div_m7_2: got q=%h r=%h lat=%0d expected q=fffffffd r=ffffffff lat=33", quotient, remainder, lat);
        else passCount++;
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat);
        checkCount++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'd1)
            $display("[TB] FAIL div_7_m2: got q=%h r=%h expected q=fffffffd r=00000001", quotient, remainder);
        else passCount++;
    endtask

    task automatic test_boundaries();
        int lat;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
        checkCount++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0 || div_zero !== 1'b0)
            $display("[TB] FAIL div_overflow: got q=%h r=%h z=%b expected q=80000000 r=00000000 z=0", quotient, remainder, div_zero);
        else passCount++;
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
        checkCount++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0)
            $display("[TB] FAIL divu_max_1: got q=%h r=%h expected q=ffffffff r=00000000", quotient, remainder);
        else passCount++;
        run_op(32'd5, 32'hFFFF_FFF0, 1'b0, lat);
        checkCount++;
        if (quotient !== 32'd0 || remainder !== 32'd5)
            $display("[TB] FAIL divu_small: got q=%h r=%h expected q=00000000 r=00000005", quotient, remainder);
        else passCount++;
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(32'd55, 32'd0, 1'b0, lat);
        checkCount++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd55 || div_zero !== 1'b1 || lat !== LATENCY)
            $display("[TB] FAIL divu_by_zero: got q=%h r=%h z=%b lat=%0d expected q=ffffffff r=00000037 z=1 lat=33", quotient, remainder, div_zero, lat);
        else passCount++;
        run_op(32'hFFFF_FFC9, 32'd0, 1'b1, lat);
        checkCount++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FFC9 || div_zero !== 1'b1)
            $display("[TB] FAIL div_by_zero: got q=%h r=%h z=%b expected q=ffffffff r=ffffffc9 z=1", quotient, remainder, div_zero);
        else passCount++;
    endtask

    task automatic test_ignore_start();
        int lat;
        int extra;
        start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd33;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            if (lat == 4 || lat == 19) begin
                start = 1'b1; signed_op = 1'b1; dividend = 32'hFFFF_0000; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        checkCount++;
        if (quotient !== 32'd30 || remainder !== 32'd10 || lat !== LATENCY)
            $display("[TB] FAIL ignore_start: got q=%h r=%h lat=%0d expected q=0000001e r=0000000a lat=33", quotient, remainder, lat);
        else passCount++;
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checkCount++;
        if (extra !== 0) $display("[TB] FAIL ignore_no_second_op: got %0d active cycles expected 0", extra);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(32'd81, 32'd9, 1'b0, lat);
        // Still in the done cycle: issue the next op right away.
        start = 1'b1; signed_op = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd7;
        checkCount++;
        if (quotient !== 32'd9 || remainder !== 32'd0)
            $display("[TB] FAIL b2b_first: got q=%h r=%h expected q=00000009 r=00000000", quotient, remainder);
        else passCount++;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        checkCount++;
        if (busy !== 1'b1) $display("[TB] FAIL b2b_accept: got busy=%b expected 1", busy);
        else passCount++;
        lat = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        checkCount++;
        if (quotient !== 32'hFFFF_FFF2 || remainder !== 32'hFFFF_FFFE || lat !== LATENCY)
            $display("[TB] FAIL b2b_second: got q=%h r=%h lat=%0d expected q=fffffff2 r=fffffffe lat=33", quotient, remainder, lat);
        else passCount++;
    endtask

    task automatic test_reset_midop();
        int lat;
        int seen;
        start = 1'b1; signed_op = 1'b0; dividend = 32'd12345; divisor = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if ({busy, done, div_zero} !== 3'b000 || quotient !== '0 || remainder !== '0)
            $display("[TB] FAIL reset_midop: got busy=%b done=%b z=%b q=%h r=%h expected all zero", busy, done, div_zero, quotient, remainder);
        else passCount++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checkCount++;
        if (seen !== 0) $display("[TB] FAIL reset_abandon: got %0d active cycles expected 0", seen);
        else passCount++;
        run_op(32'd9, 32'd3, 1'b0, lat);
        checkCount++;
        if (quotient !== 32'd3 || remainder !== 32'd0 || lat !== LATENCY)
            $display("[TB] FAIL after_reset_9_3: got q=%h r=%h lat=%0d expected q=00000003 r=00000000 lat=33", quotient, remainder, lat);
        else passCount++;
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] a, b, eq, er;
        logic s, ez;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 255);
                2:       b = -$urandom_range(1, 255);
                default: b = (i % 3 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            if (i % 4 == 1) a = a >> $urandom_range(0, 31);
            model(a, b, s, eq, er, ez);
            run_op(a, b, s, lat);
            checkCount++;
            if (quotient !== eq || remainder !== er || div_zero !== ez || lat !== LATENCY)
                $display("[TB] FAIL random_%0d: a=%h b=%h s=%b got q=%h r=%h z=%b lat=%0d expected q=%h r=%h z=%b lat=%0d",
                         i, a, b, s, quotient, remainder, div_zero, lat, eq, er, ez, LATENCY);
            else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_boundaries();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
